product_accumulator: RTL and testbench
======================================

# product_accumulator

Downstream consumer of the registered signed multiplier stage. Accepts one signed 2N-bit product per cycle together with its overflow flag, sums a programmable number of products into a wide signed accumulator, and presents the block sum on a valid/ready output port. Used to build dot products and MAC loops on top of the multiplier without changing the multiplier itself.

## Interface
- N, 32, operand width of the upstream multiplier; products are 2N bits
- GUARD, 8, extra accumulator bits; ACC_W = 2N+GUARD
- CNT_W, 8, width of the length and count fields
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  product/prod_ovf valid this cycle
- in_ready  out  1  block accepts a beat; beat transfers when in_valid & in_ready
- product  in  2N  signed product from the multiplier output register
- prod_ovf  in  1  multiplier overflow flag for this product
- len  in  CNT_W  products per block; sampled on the first beat of a block; 0 treated as 1
- out_valid  out  1  block result available
- out_ready  in  1  consumer takes result; transfers when out_valid & out_ready
- acc_out  out  ACC_W  signed block sum
- out_ovf  out  1  sticky: any prod_ovf in block, or accumulator overflow
- count_out  out  CNT_W  number of products summed in this block
- busy  out  1  state is ACCUM or HOLD

## Operation
- States: IDLE, ACCUM, HOLD.
- IDLE: in_ready=1. On beat: len_q<=max(len,1); acc<=sign-extended product; cnt<=1; ovf<=prod_ovf. Go HOLD if len_q==1, else ACCUM.
- ACCUM: in_ready=1. On beat: acc<=acc+sext(product); cnt<=cnt+1; ovf<=ovf|prod_ovf|add_ovf. Go HOLD when the incremented cnt equals len_q. No beat: hold all state.
- HOLD: in_ready=0, out_valid=1; acc_out/out_ovf/count_out stable until transfer. On out_ready: go IDLE, clear acc, cnt and ovf.
- add_ovf: both addends have the same sign and the sum's sign differs (ACC_W-bit signed add).
- len changes after the first beat of a block have no effect until the next block.
- acc_out, count_out and out_ovf always reflect the internal registers. They are meaningful only while out_valid=1.

## Timing
- Reset (asynchronous, any state, mid-block included): state=IDLE, acc=0, cnt=0, len_q=0, ovf=0. Outputs: out_valid=0, acc_out=0, out_ovf=0, count_out=0, busy=0, in_ready=1. A partial block is discarded.
- Throughput: one product per clock in IDLE/ACCUM.
- Latency: out_valid rises on the clock edge that accepts the final beat, so it is visible the cycle after that beat.
- in_ready drops in the same cycle out_valid rises. It returns to 1 the cycle after the output transfer. Minimum one bubble cycle between blocks.
- in_ready and out_valid depend only on state, with no combinational path from inputs.
- Upstream must hold product and prod_ovf stable while in_valid=1 and in_ready=0.

## Configuration
- ACC_SATURATE_EN defined: on add_ovf, acc clamps to the most positive value (positive overflow) or the most negative value (negative overflow). Further adds in the same direction keep it clamped; an add of the opposite sign proceeds from the clamped value. out_ovf is still set.
- ACC_SATURATE_EN undefined: acc wraps modulo 2^ACC_W. out_ovf is still set.

## Test plan
- Reset, then len=4, products 3, -5, 10, 7 on back-to-back cycles -> out_valid the cycle after the 4th beat, acc_out=15, count_out=4, out_ovf=0, in_ready=0 until out_ready.
- len=0, single product -2^63 -> behaves as len=1: acc_out=-2^63 sign-extended, count_out=1.
- len=3 with prod_ovf=1 on beat 2 only -> out_ovf=1, sum unaffected.
- GUARD=0, len=2, products 2^63-1 twice -> out_ovf=1. With ACC_SATURATE_EN, acc_out=2^63-1. Without it, acc_out=-2 (wrapped).
- out_ready held low 5 cycles in HOLD, in_valid=1 throughout -> outputs stable, no beats consumed, in_ready=0. Release -> IDLE next cycle, the next beat is accepted.
- rst asserted after 2 of 4 beats -> all outputs return to their reset values immediately. A new block of len=1, product 9 then yields acc_out=9, count_out=1.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier output stage, the product accumulator
// and its block-sum consumer.
interface product_accumulator_if #(
    parameter int N     = 32,
    parameter int GUARD = 8,
    parameter int CNT_W = 8
);
    localparam int ACC_W = 2*N + GUARD;

    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   product;
    logic             prod_ovf;
    logic [CNT_W-1:0] len;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             out_ovf;
    logic [CNT_W-1:0] count_out;
    logic             busy;

    modport master (
        output in_valid, product, prod_ovf, len, out_ready,
        input  in_ready, out_valid, acc_out, out_ovf, count_out, busy
    );

    modport slave (
        input  in_valid, product, prod_ovf, len, out_ready,
        output in_ready, out_valid, acc_out, out_ovf, count_out, busy
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums blocks of signed multiplier products into a wide accumulator.
// Define ACC_SATURATE_EN to clamp on accumulator overflow instead of wrapping.
module product_accumulator #(
    parameter int N     = 32,
    parameter int GUARD = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    product_accumulator_if.slave  bus
);
    localparam int P_W   = 2*N;
    localparam int ACC_W = P_W + GUARD;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic        [CNT_W-1:0]  cnt;
    logic        [CNT_W-1:0]  len_q;
    logic                     ovf;

    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     add_ovf;
    logic                     beat;
    logic        [CNT_W-1:0]  len_eff;
    logic        [CNT_W-1:0]  cnt_inc;

    always_comb begin
        prod_ext = ACC_W'($signed(bus.product));
        sum      = acc + prod_ext;
        add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef ACC_SATURATE_EN
        // Direction of overflow follows the shared sign of the two addends.
        acc_next = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
        acc_next = sum;
`endif
        len_eff  = (bus.len == '0) ? CNT_W'(1) : bus.len;
        cnt_inc  = cnt + CNT_W'(1);
        beat     = bus.in_valid && (state != HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        len_q <= len_eff;
                        acc   <= prod_ext;
                        cnt   <= CNT_W'(1);
                        ovf   <= bus.prod_ovf;
                        state <= (len_eff == CNT_W'(1)) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc   <= acc_next;
                        cnt   <= cnt_inc;
                        ovf   <= ovf | bus.prod_ovf | add_ovf;
                        if (cnt_inc == len_q) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode the state register only, so no input reaches them combinationally.
    assign bus.in_ready  = (state != HOLD);
    assign bus.out_valid = (state == HOLD);
    assign bus.busy      = (state != IDLE);
    assign bus.acc_out   = acc;
    assign bus.count_out = cnt;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: default instance plus a GUARD=0 instance
// for overflow handling (expectations follow ACC_SATURATE_EN).
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic signed [71:0] acc;
        logic [7:0]         cnt;
        logic               ovf;
    } exp_t;

    exp_t               sbq[$];
    logic [63:0]        sbq0[$];
    logic signed [63:0] stim_prod[8];
    logic               stim_ovf[8];

    product_accumulator_if #(.N(32), .GUARD(8), .CNT_W(8)) m();
    product_accumulator_if #(.N(32), .GUARD(0), .CNT_W(8)) g0();

    product_accumulator #(.N(32), .GUARD(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(m)
    );
    product_accumulator #(.N(32), .GUARD(0), .CNT_W(8)) dut_g0 (
        .clk(clk), .rst(rst), .bus(g0)
    );

    function automatic logic out_of_range(input logic signed [127:0] t, input int w);
        logic signed [127:0] lim;
        lim = 128'sd1 <<< (w - 1);
        return (t >= lim) || (t < -lim);
    endfunction

    function automatic logic signed [127:0] model_acc(input logic signed [127:0] t, input int w);
        logic signed [127:0] lim;
        lim = 128'sd1 <<< (w - 1);
`ifdef ACC_SATURATE_EN
        if (t >= lim) return lim - 1;
        if (t < -lim) return -lim;
`endif
        return t;
    endfunction

    task automatic drive_block(input int n, input logic [7:0] lenv);
        logic signed [127:0] t;
        logic eo;
        t  = '0;
        eo = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m.in_valid = 1'b1;
            m.product  = stim_prod[i];
            m.prod_ovf = stim_ovf[i];
            m.len      = (i == 0) ? lenv : lenv + 8'd5;
            total++;
            if (m.in_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL beat_ready beat=%0d in_ready=%b want 1", i, m.in_ready);
            end
            t = t + {{64{stim_prod[i][63]}}, stim_prod[i]};
            if (out_of_range(t, 72)) eo = 1'b1;
            t  = model_acc(t, 72);
            eo = eo | stim_ovf[i];
        end
        @(negedge clk);
        m.in_valid = 1'b0;
        m.prod_ovf = 1'b0;
        sbq.push_back('{acc: t[71:0], cnt: 8'(n), ovf: eo});
    endtask

    task automatic collect_result(input int stall, input string name);
        exp_t e;
        int   waited;
        waited = 0;
        while (m.out_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (m.out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_timeout out_valid=%b want 1", name, m.out_valid);
            if (sbq.size() > 0) void'(sbq.pop_front());
            return;
        end
        total++;
        if (waited != 0) begin
            bad++;
            $display("[TB] FAIL %s_latency extra_cycles=%0d want 0", name, waited);
        end
        e = sbq.pop_front();
        m.out_ready = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                m.in_valid = 1'b1;
                m.product  = 64'sd1234;
                @(negedge clk);
            end
            total++;
            if (m.acc_out !== e.acc) begin
                bad++;
                $display("[TB] FAIL %s_acc cyc=%0d got=%0d want=%0d", name, s, $signed(m.acc_out), e.acc);
            end
            total++;
            if (m.count_out !== e.cnt || m.out_ovf !== e.ovf) begin
                bad++;
                $display("[TB] FAIL %s_cnt_ovf cyc=%0d got=%0d/%b want=%0d/%b", name, s, m.count_out, m.out_ovf, e.cnt, e.ovf);
            end
            total++;
            if (m.in_ready !== 1'b0 || m.busy !== 1'b1 || m.out_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL %s_hold_flags cyc=%0d rdy/busy/ov=%b%b%b want 011", name, s, m.in_ready, m.busy, m.out_valid);
            end
        end
        m.out_ready = 1'b1;
        @(negedge clk);
        m.out_ready = 1'b0;
        m.in_valid  = 1'b0;
        total++;
        if (m.out_valid !== 1'b0 || m.in_ready !== 1'b1 || m.busy !== 1'b0 || m.count_out !== 8'd0 || m.acc_out !== 72'd0) begin
            bad++;
            $display("[TB] FAIL %s_release ov/rdy/busy=%b%b%b cnt=%0d acc=%0d want 010 0 0", name, m.out_valid, m.in_ready, m.busy, m.count_out, $signed(m.acc_out));
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (m.out_valid !== 1'b0 || m.acc_out !== 72'd0 || m.out_ovf !== 1'b0 || m.count_out !== 8'd0 || m.busy !== 1'b0 || m.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_state ov=%b acc=%0d ovf=%b cnt=%0d busy=%b rdy=%b want 0 0 0 0 0 1", m.out_valid, $signed(m.acc_out), m.out_ovf, m.count_out, m.busy, m.in_ready);
        end
        total++;
        if (g0.busy !== 1'b0 || g0.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_g0 busy=%b rdy=%b want 0 1", g0.busy, g0.in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        stim_prod[0] = 64'sd3;  stim_prod[1] = -64'sd5;
        stim_prod[2] = 64'sd10; stim_prod[3] = 64'sd7;
        for (int i = 0; i < 4; i++) stim_ovf[i] = 1'b0;
        drive_block(4, 8'd4);
        total++;
        if (sbq[0].acc !== 72'sd15) begin
            bad++;
            $display("[TB] FAIL basic_model got=%0d want=15", sbq[0].acc);
        end
        collect_result(0, "basic");
    endtask

    task automatic test_len_zero();
        stim_prod[0] = 64'sh8000_0000_0000_0000;
        stim_ovf[0]  = 1'b0;
        drive_block(1, 8'd0);
        collect_result(0, "len_zero");
    endtask

    task automatic test_prod_ovf();
        stim_prod[0] = 64'sd100; stim_prod[1] = -64'sd40; stim_prod[2] = 64'sd5;
        stim_ovf[0]  = 1'b0;     stim_ovf[1]  = 1'b1;     stim_ovf[2]  = 1'b0;
        drive_block(3, 8'd3);
        collect_result(0, "prod_ovf");
    endtask

    task automatic test_hold_stall();
        stim_prod[0] = 64'sd11; stim_prod[1] = 64'sd22;
        stim_ovf[0]  = 1'b0;    stim_ovf[1]  = 1'b0;
        drive_block(2, 8'd2);
        collect_result(5, "stall");
        stim_prod[0] = -64'sd77;
        drive_block(1, 8'd1);
        collect_result(0, "after_stall");
    endtask

    task automatic test_back_to_back();
        int n;
        for (int b = 0; b < 4; b++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                stim_prod[i] = {$urandom, $urandom};
                stim_ovf[i]  = ($urandom_range(0, 7) == 0);
            end
            drive_block(n, 8'(n));
            collect_result(b % 2, "b2b");
        end
    endtask

    task automatic test_guard_overflow();
        logic [63:0] e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            g0.in_valid = 1'b1;
            g0.product  = 64'h7FFF_FFFF_FFFF_FFFF;
            g0.prod_ovf = 1'b0;
            g0.len      = 8'd2;
        end
`ifdef ACC_SATURATE_EN
        sbq0.push_back(64'h7FFF_FFFF_FFFF_FFFF);
`else
        sbq0.push_back(64'hFFFF_FFFF_FFFF_FFFE);
`endif
        @(negedge clk);
        g0.in_valid = 1'b0;
        e = sbq0.pop_front();
        total++;
        if (g0.out_valid !== 1'b1 || g0.acc_out !== e) begin
            bad++;
            $display("[TB] FAIL guard_acc ov=%b got=%h want=%h", g0.out_valid, g0.acc_out, e);
        end
        total++;
        if (g0.out_ovf !== 1'b1 || g0.count_out !== 8'd2) begin
            bad++;
            $display("[TB] FAIL guard_ovf_cnt got=%b/%0d want=1/2", g0.out_ovf, g0.count_out);
        end
        g0.out_ready = 1'b1;
        @(negedge clk);
        g0.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m.in_valid = 1'b1; m.product = 64'sd50; m.prod_ovf = 1'b0; m.len = 8'd4;
        @(negedge clk);
        m.product = 64'sd60;
        @(negedge clk);
        m.in_valid = 1'b0;
        total++;
        if (m.busy !== 1'b1 || m.count_out !== 8'd2 || m.acc_out !== 72'sd110) begin
            bad++;
            $display("[TB] FAIL partial busy=%b cnt=%0d acc=%0d want 1 2 110", m.busy, m.count_out, $signed(m.acc_out));
        end
        rst = 1'b1;
        #1;
        total++;
        if (m.out_valid !== 1'b0 || m.acc_out !== 72'd0 || m.count_out !== 8'd0 || m.busy !== 1'b0 || m.in_ready !== 1'b1 || m.out_ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset ov=%b acc=%0d cnt=%0d busy=%b rdy=%b ovf=%b", m.out_valid, $signed(m.acc_out), m.count_out, m.busy, m.in_ready, m.out_ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        stim_prod[0] = 64'sd9;
        stim_ovf[0]  = 1'b0;
        drive_block(1, 8'd1);
        collect_result(0, "post_reset");
    endtask

    initial begin
        m.in_valid = 1'b0;  m.product = '0;  m.prod_ovf = 1'b0;  m.len = '0;  m.out_ready = 1'b0;
        g0.in_valid = 1'b0; g0.product = '0; g0.prod_ovf = 1'b0; g0.len = '0; g0.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_len_zero();
        test_prod_ovf();
        test_hold_stall();
        test_back_to_back();
        test_guard_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
